// File: rtl/lut_reader_pkg.sv
// lut_reader_pkg: shared FSM state type and geometry helpers for the LUT readback engine.
package lut_reader_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  function automatic int calc_epw(input int out_bits, input int word_bits);
    return word_bits / out_bits;
  endfunction
  function automatic int calc_nwords(input int in_bits, input int out_bits, input int word_bits);
    return (1 << in_bits) / calc_epw(out_bits, word_bits);
  endfunction
  function automatic int cnt_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit cfg_ok(input int in_bits, input int out_bits, input int word_bits);
    return (word_bits % out_bits == 0) && ((1 << in_bits) % calc_epw(out_bits, word_bits) == 0);
  endfunction
endpackage

// File: rtl/lut_word_packer.sv
// lut_word_packer: packs neuron samples LSB-first into words and holds them on a valid/ready output.
module lut_word_packer
  import lut_reader_pkg::*;
#(
  parameter int OUT_BITS  = 1,
  parameter int WORD_BITS = 32,
  parameter int SLOT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [SLOT_W-1:0]    slot,
  input  logic [OUT_BITS-1:0]  lut_out,
  input  logic                 last_word,
  input  logic                 m_ready,
  output logic                 stall,
  output logic                 handshake,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last
);
  localparam int EPW = calc_epw(OUT_BITS, WORD_BITS);
  logic [WORD_BITS-1:0] pack_q, pack_d, pack_ins, data_q, data_d;
  logic valid_q, valid_d, last_slot, take, complete;
  always_comb begin
    pack_ins = pack_q;
    pack_ins[int'(slot) * OUT_BITS +: OUT_BITS] = lut_out;
    handshake = valid_q && m_ready;
    last_slot = slot == SLOT_W'(EPW - 1);
    // A completing capture may only proceed if the output slot frees up this cycle.
    stall = capture && last_slot && valid_q && !m_ready;
    take = capture && !stall;
    complete = take && last_slot;
    pack_d = take ? (complete ? '0 : pack_ins) : pack_q;
    data_d = complete ? pack_ins : data_q;
    valid_d = complete ? 1'b1 : handshake ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = valid_q && last_word;
endmodule

// File: rtl/lut_table_reader.sv
// lut_table_reader: sweeps every input code of a combinational LUT neuron and streams the packed truth table.
module lut_table_reader
  import lut_reader_pkg::*;
#(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IN_BITS-1:0]   lut_in,
  input  logic [OUT_BITS-1:0]  lut_out,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);
  localparam int EPW    = calc_epw(OUT_BITS, WORD_BITS);
  localparam int NWORDS = calc_nwords(IN_BITS, OUT_BITS, WORD_BITS);
  localparam int SLOT_W = cnt_bits(EPW);
  localparam int CNT_W  = cnt_bits(NWORDS);
  if (!cfg_ok(IN_BITS, OUT_BITS, WORD_BITS)) begin : g_cfg_bad
    $error("lut_table_reader: WORD_BITS must be a multiple of OUT_BITS and EPW must divide 2**IN_BITS");
  end
  state_t state_q, state_d;
  logic [IN_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [SLOT_W-1:0] slot;
  logic capture, stall, handshake, last_word;
  assign slot = SLOT_W'(addr_q & IN_BITS'(EPW - 1));
  assign last_word = wcnt_q == CNT_W'(NWORDS - 1);
  assign capture = state_q == SWEEP;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wcnt_d = handshake ? wcnt_q + 1'b1 : wcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SWEEP;
        addr_d = '0;
        wcnt_d = '0;
      end
      SWEEP: if (!stall) begin
        addr_d = addr_q + 1'b1;
        state_d = &addr_q ? DRAIN : SWEEP;
      end
      DRAIN: state_d = (handshake && last_word) ? DONE : DRAIN;
      default: begin
        state_d = IDLE;
        addr_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign busy   = state_q == SWEEP || state_q == DRAIN;
  assign done   = state_q == DONE;
  assign lut_in = addr_q;
  lut_word_packer #(
    .OUT_BITS (OUT_BITS),
    .WORD_BITS(WORD_BITS),
    .SLOT_W   (SLOT_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .slot     (slot),
    .lut_out  (lut_out),
    .last_word(last_word),
    .m_ready  (m_ready),
    .stall    (stall),
    .handshake(handshake),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last)
  );
endmodule

// File: tb/tb_lut_table_reader.sv
// tb_lut_table_reader: scoreboard bench sweeping modelled neurons through the reader at two output widths.
module tb_lut_table_reader;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 1;
  logic busy, done, m_valid, m_last, lut_out;
  logic [7:0] lut_in;
  logic [31:0] m_data;
  logic start2 = 0, m_ready2 = 1, busy2, done2, m_valid2, m_last2;
  logic [7:0] lut_in2;
  logic [1:0] lut_out2;
  logic [31:0] m_data2;
  int mode = 0;
  logic tbl [256];
  int n_tests = 0, n_fail = 0, n_done = 0;
  logic [32:0] exp_q [$], exp2_q [$];
  logic [32:0] e1, e2;
  logic prev_hold = 0;
  logic [31:0] prev_data = 0;

  always #5 clk = ~clk;

  assign lut_out  = mode == 0 ? lut_in[0] : mode == 1 ? (lut_in == 8'hFF) : tbl[lut_in];
  assign lut_out2 = lut_in2[1:0];

  lut_table_reader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .lut_in(lut_in), .lut_out(lut_out), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  lut_table_reader #(.IN_BITS(8), .OUT_BITS(2), .WORD_BITS(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .lut_in(lut_in2), .lut_out(lut_out2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_last(m_last2)
  );

  function automatic logic neuron(input int md, input logic [7:0] x);
    return md == 0 ? x[0] : md == 1 ? (x == 8'hFF) : tbl[x];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_sweep(input int md);
    logic [31:0] w;
    for (int j = 0; j < 8; j++) begin
      w = '0;
      for (int e = 0; e < 32; e++) w[e] = neuron(md, 8'(j * 32 + e));
      exp_q.push_back({j == 7, w});
    end
  endtask

  task automatic push_sweep2();
    logic [31:0] w;
    logic [7:0] x;
    for (int j = 0; j < 16; j++) begin
      w = '0;
      for (int e = 0; e < 16; e++) begin
        x = 8'(j * 16 + e);
        w[2*e +: 2] = x % 4;
      end
      exp2_q.push_back({j == 15, w});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && m_valid) chk("hold_data", m_data, prev_data);
      if (m_last && !m_valid) chk("last_without_valid", m_last, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          e1 = exp_q.pop_front();
          chk("word", {m_last, m_data}, e1);
        end
      end
      if (m_valid2 && m_ready2) begin
        if (exp2_q.size() == 0) chk("extra_word2", 1, 0);
        else begin
          e2 = exp2_q.pop_front();
          chk("word2", {m_last2, m_data2}, e2);
        end
      end
      if (done) n_done++;
    end
    prev_hold = rst_n && m_valid && !m_ready;
    prev_data = m_data;
  end

  // stall_len > 0: m_ready low until m_valid has been seen that many cycles; < 0: random m_ready.
  task automatic run(input int md, input int stall_len, input int restart_at, input int dexp);
    int held, dcyc, dones0;
    held = 0;
    dones0 = n_done;
    mode = md;
    push_sweep(md);
    m_ready = stall_len == 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    dcyc = 0;
    while (!done && dcyc < 3000) begin
      @(posedge clk); #1;
      dcyc++;
      start = dcyc == restart_at;
      if (stall_len < 0) m_ready = $urandom_range(0, 3) != 0;
      else if (!m_ready && m_valid) begin
        held++;
        if (held == stall_len) begin
          chk("stall_lut_in", lut_in, 63);
          m_ready = 1;
        end
      end
    end
    start = 0;
    if (dexp >= 0) chk("done_cycle", dcyc, dexp);
    chk("busy_at_done", {busy, done}, 2'b01);
    m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", n_done - dones0, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (tbl[i]) tbl[i] = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {busy, done, m_valid, m_last}, 0);
    chk("reset_lut_in", lut_in, 0);
    chk("reset_m_data", m_data, 0);
    rst_n = 1;
    run(0, 0, 0, 257);
    run(1, 0, 0, 257);
    run(2, 41, 0, 266);
    run(0, 0, 100, 257);
    foreach (tbl[i]) tbl[i] = 1'($urandom);
    run(2, -1, 0, -1);
    mode = 2;
    push_sweep(2);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 300 && lut_in != 8'd100; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_point", lut_in, 100);
    rst_n = 0;
    #1;
    chk("abort_ctl", {busy, done, m_valid, m_last}, 0);
    chk("abort_lut_in", lut_in, 0);
    chk("abort_m_data", m_data, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    run(2, 0, 0, 257);
    push_sweep2();
    @(posedge clk); #1 start2 = 1;
    @(posedge clk); #1 start2 = 0;
    begin
      int dcyc2;
      dcyc2 = 0;
      while (!done2 && dcyc2 < 3000) begin
        @(posedge clk); #1;
        dcyc2++;
      end
      chk("done_cycle2", dcyc2, 257);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("queue2_empty", exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
